neuron_layer_scheduler: RTL and testbench
=========================================

NEURON_LAYER_SCHEDULER -- requirements
Module: neuron_layer_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 8, number of neurons sharing one input-current calculator (>=2).
REQ-002 Parameter M, default 24, spike vector width, equal to the calculator's M.
REQ-003 Parameter CALC_LAT, default 2, consecutive calc_enable cycles for a valid calculator result (>=1).
REQ-004 clk  input  1  single clock, all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse, begin one timestep over all neurons.
REQ-007 input_spikes  input  M  presynaptic spike vector, sampled only in LOAD.
REQ-008 calc_enable  output  1  enable to the shared calculator.
REQ-009 calc_spikes  output  M  spike snapshot driven to the calculator.
REQ-010 weight_sel  output  clog2(N_NEURONS)  index of the neuron whose weight row feeds the calculator.
REQ-011 calc_current  input  8  signed calculator result.
REQ-012 out_valid  output  1  neuron_current and neuron_idx are valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 neuron_idx  output  clog2(N_NEURONS)  neuron the current belongs to.
REQ-015 neuron_current  output  8  captured signed input current.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse after the last neuron is accepted.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, CALC, CAPTURE, OUT, DONE.
REQ-019 IDLE->LOAD when start=1, otherwise remain in IDLE.
REQ-020 start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-021 LOAD (1 cycle) SHALL register input_spikes into calc_spikes, clear index to 0, and set flag zero_step = (input_spikes == 0).
REQ-022 LOAD->CALC if zero_step=0, LOAD->CAPTURE if zero_step=1.
REQ-023 CALC SHALL assert calc_enable for exactly CALC_LAT consecutive cycles (cycle counter), then go to CAPTURE.
REQ-024 calc_spikes and weight_sel SHALL be stable throughout CALC and CAPTURE; weight_sel equals index.
REQ-025 CAPTURE (1 cycle, calc_enable=0) SHALL register calc_current into neuron_current, or 8'h00 when zero_step=1, and index into neuron_idx, then go to OUT.
REQ-026 OUT SHALL hold out_valid=1 with neuron_current and neuron_idx stable until out_ready=1.
REQ-027 On OUT with out_ready=1: if index=N_NEURONS-1 go to DONE, else increment index and go to CALC (or to CAPTURE when zero_step=1).
REQ-028 DONE (1 cycle) SHALL assert done=1, then go to IDLE.
REQ-029 With out_ready held high and zero_step=0, the result for neuron k SHALL be valid 5+4k cycles after the start cycle, and done SHALL follow 2+4N cycles after it (34 for N=8).
REQ-030 With zero_step=1, calc_enable SHALL never assert, neuron k SHALL be valid at 3+2k, and done SHALL follow at 2+2N (18 for N=8).
REQ-031 Index SHALL never exceed N_NEURONS-1 and SHALL not wrap within a timestep.
REQ-032 calc_enable, out_valid and done SHALL be mutually exclusive.

Reset
REQ-033 When reset=1 at a clock edge, state SHALL go to IDLE, index and cycle counter to 0, and zero_step to 0.
REQ-034 The same reset SHALL set calc_enable, out_valid, done and busy to 0, and calc_spikes, weight_sel, neuron_idx and neuron_current to 0.
REQ-035 Reset mid-timestep SHALL abandon the timestep without a done pulse.
REQ-036 A start asserted together with reset SHALL be ignored.

Structure
REQ-037 Shared package snn_sched_pkg SHALL hold the state enumeration and the CALC_LAT default constant.
REQ-038 The block SHALL contain no sub-modules; the calculator and the weight-row mux live outside it.

Verification
REQ-039 N=8, spikes=24'h000001, out_ready=1, calculator model returning 8'h10+k -> 8 results in order, idx 0..7, values 0x10..0x17, first at +5, done at +34.
REQ-040 spikes=0 -> 8 results of 0x00, calc_enable never high, done at +18.
REQ-041 out_ready=0 for 3 cycles at neuron 2 -> out_valid held, neuron_current and neuron_idx unchanged, done delayed by exactly 3 cycles.
REQ-042 start re-pulsed during CALC, and input_spikes changed after LOAD -> no effect, calc_spikes keeps the snapshot.
REQ-043 reset asserted while in OUT for neuron 4 -> next cycle IDLE, all outputs 0, no done; a following start runs a full timestep from idx 0.
REQ-044 Calculator model returning 8'h80 and 8'h7F -> neuron_current 0x80 and 0x7F passed through unaltered.

Source files
------------

// File: rtl/snn_sched_pkg.sv
// Shared definitions for the neuron layer scheduler: FSM state encoding and
// the default calculator latency.
package snn_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_CAPTURE,
        S_OUT,
        S_DONE
    } sched_state_t;

    localparam int CALC_LAT_DEFAULT = 2;

endpackage

// File: rtl/neuron_layer_scheduler.sv
// Time-multiplexes one input-current calculator across N_NEURONS neurons:
// snapshots the spike vector once per timestep, then walks the neurons in order.
module neuron_layer_scheduler
    import snn_sched_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int M         = 24,
    parameter int CALC_LAT  = CALC_LAT_DEFAULT,
    localparam int IW       = $clog2(N_NEURONS),
    localparam int CW       = $clog2(CALC_LAT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [M-1:0]      input_spikes,
    output logic              calc_enable,
    output logic [M-1:0]      calc_spikes,
    output logic [IW-1:0]     weight_sel,
    input  logic signed [7:0] calc_current,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IW-1:0]     neuron_idx,
    output logic signed [7:0] neuron_current,
    output logic              busy,
    output logic              done
);

    sched_state_t  state;
    logic [IW-1:0] index;
    logic [CW-1:0] cyc;
    logic          zero_step;

    // The weight row always follows the neuron currently being processed.
    assign weight_sel = index;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            index          <= '0;
            cyc            <= '0;
            zero_step      <= 1'b0;
            calc_enable    <= 1'b0;
            calc_spikes    <= '0;
            out_valid      <= 1'b0;
            neuron_idx     <= '0;
            neuron_current <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    calc_spikes <= input_spikes;
                    index       <= '0;
                    cyc         <= '0;
                    zero_step   <= (input_spikes == '0);
                    // An all-zero spike vector yields zero current; skip the calculator.
                    if (input_spikes == '0) begin
                        state <= S_CAPTURE;
                    end else begin
                        state       <= S_CALC;
                        calc_enable <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (cyc == CW'(CALC_LAT - 1)) begin
                        cyc         <= '0;
                        calc_enable <= 1'b0;
                        state       <= S_CAPTURE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    neuron_current <= zero_step ? 8'sh00 : calc_current;
                    neuron_idx     <= index;
                    out_valid      <= 1'b1;
                    state          <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (index == IW'(N_NEURONS - 1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                            if (zero_step) begin
                                state <= S_CAPTURE;
                            end else begin
                                state       <= S_CALC;
                                calc_enable <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Self-checking bench: directed vector table, reset/start corner sequences and
// random timesteps against a cycle-arithmetic reference of the schedule.
module tb_neuron_layer_scheduler;
    import snn_sched_pkg::*;

    localparam int N   = 8;
    localparam int M   = 24;
    localparam int LAT = 2;
    localparam int IW  = 3;

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic [M-1:0]  input_spikes, calc_spikes;
    logic          calc_enable, out_valid, busy, done;
    logic [IW-1:0] weight_sel, neuron_idx;
    logic [7:0]    calc_current, neuron_current;

    always #5 clk = ~clk;

    neuron_layer_scheduler #(.N_NEURONS(N), .M(M), .CALC_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .input_spikes(input_spikes),
        .calc_enable(calc_enable), .calc_spikes(calc_spikes), .weight_sel(weight_sel),
        .calc_current(calc_current), .out_valid(out_valid), .out_ready(out_ready),
        .neuron_idx(neuron_idx), .neuron_current(neuron_current), .busy(busy), .done(done)
    );

    // Calculator model: result is only meaningful after exactly LAT enable cycles for the same row.
    int         calc_mode;
    int         run;
    logic [IW-1:0] run_sel;

    function automatic logic [7:0] calc_val(input int mode, input int sel);
        if (mode == 0) return 8'(8'h10 + sel);
        return (sel % 2 == 1) ? 8'h7F : 8'h80;
    endfunction

    always @(posedge clk) begin
        if (reset) run <= 0;
        else if (calc_enable) begin
            run     <= run + 1;
            run_sel <= weight_sel;
        end else run <= 0;
    end

    always_comb begin
        calc_current = 8'hEE;
        if (run == LAT && run_sel == weight_sel) calc_current = calc_val(calc_mode, int'(weight_sel));
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference schedule, from cycle arithmetic on acceptance times.
    bit rdy[0:1023];
    int exp_valid[N];
    int exp_acc[N];
    int exp_done;

    task automatic build_expect(input bit zero, input int stall_k, input int stall_n);
        int t, a;
        t = zero ? 3 : 3 + LAT;
        for (int k = 0; k < N; k++) begin
            exp_valid[k] = t;
            a = t;
            if (k == stall_k) begin
                for (int s = 0; s < stall_n; s++) rdy[t + s] = 1'b0;
                a = t + stall_n;
            end
            while (!rdy[a] && a < 1023) a++;
            exp_acc[k] = a;
            t = a + (zero ? 2 : 2 + LAT);
        end
        exp_done = exp_acc[N-1] + 1;
    endtask

    task automatic run_step(input logic [M-1:0] spikes, input int mode, input bit rnd_ready,
                            input int stall_k, input int stall_n,
                            output int first_valid, output int done_at);
        int  k, ce_cnt, excl_bad, sel_bad, snap_bad, hold_bad, extra_done;
        bit  seen, zero;
        logic [7:0]    held_cur;
        logic [IW-1:0] held_idx;
        zero = (spikes == '0);
        calc_mode = mode;
        for (int i = 0; i < 1024; i++) rdy[i] = rnd_ready ? ($urandom_range(9, 0) < 7) : 1'b1;
        rdy[1023] = 1'b1;
        build_expect(zero, stall_k, stall_n);
        k = 0; ce_cnt = 0; excl_bad = 0; sel_bad = 0; snap_bad = 0; hold_bad = 0; extra_done = 0;
        seen = 0; first_valid = -1; done_at = -1; held_cur = '0; held_idx = '0;
        start = 1'b1; input_spikes = spikes; out_ready = rdy[0];
        for (int c = 1; c <= exp_done + 6; c++) begin
            tick;
            start        = (c == 2 || c == 7);
            input_spikes = (c >= 2) ? M'($urandom) : spikes;
            out_ready    = rdy[c];
            if (calc_enable) begin
                ce_cnt++;
                if (weight_sel !== IW'(k)) sel_bad++;
            end
            if (int'(calc_enable) + int'(out_valid) + int'(done) > 1) excl_bad++;
            if (c >= 2 && busy && calc_spikes !== spikes) snap_bad++;
            if (out_valid && k < N) begin
                if (!seen) begin
                    seen = 1;
                    if (k == 0) first_valid = c;
                    chk($sformatf("valid_cycle n%0d", k), c, exp_valid[k]);
                    chk($sformatf("idx n%0d", k), neuron_idx, k);
                    chk($sformatf("current n%0d", k), neuron_current, zero ? 8'h00 : calc_val(mode, k));
                    held_cur = neuron_current;
                    held_idx = neuron_idx;
                end else if (neuron_current !== held_cur || neuron_idx !== held_idx) hold_bad++;
                if (rdy[c]) begin
                    k++;
                    seen = 0;
                end
            end
            if (done) begin
                if (done_at < 0) done_at = c;
                else extra_done++;
            end
        end
        start = 1'b0;
        chk("results", k, N);
        chk("done_cycle", done_at, exp_done);
        chk("calc_en_cycles", ce_cnt, zero ? 0 : N * LAT);
        chk("exclusive", excl_bad, 0);
        chk("weight_sel", sel_bad, 0);
        chk("snapshot", snap_bad, 0);
        chk("hold", hold_bad, 0);
        chk("single_done", extra_done, 0);
        chk("idle_after", busy, 0);
    endtask

    typedef struct {
        logic [M-1:0] spikes;
        int           mode;
        int           stall_k;
        int           stall_n;
        int           exp_first;
        int           exp_done;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int fv, dn, guard;
        tbl[0] = '{24'h000001, 0, -1, 0, 5, 34};
        tbl[1] = '{24'h000000, 0, -1, 0, 3, 18};
        tbl[2] = '{24'h000001, 0,  2, 3, 5, 37};
        tbl[3] = '{24'h800000, 1, -1, 0, 5, 34};
        tbl[4] = '{24'h000000, 1,  2, 3, 3, 21};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0; input_spikes = '0; calc_mode = 0;
        tick; tick;
        chk("rst calc_enable", calc_enable, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst done", done, 0);
        chk("rst busy", busy, 0);
        chk("rst calc_spikes", calc_spikes, 0);
        chk("rst weight_sel", weight_sel, 0);
        chk("rst neuron_idx", neuron_idx, 0);
        chk("rst neuron_current", neuron_current, 0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 5; i++) begin
            run_step(tbl[i].spikes, tbl[i].mode, 0, tbl[i].stall_k, tbl[i].stall_n, fv, dn);
            chk($sformatf("tbl%0d first", i), fv, tbl[i].exp_first);
            chk($sformatf("tbl%0d done", i), dn, tbl[i].exp_done);
        end

        // Reset while neuron 4 is on the output.
        calc_mode = 0; start = 1'b1; input_spikes = 24'h000001; out_ready = 1'b1;
        tick;
        start = 1'b0;
        guard = 0;
        while (!(out_valid && neuron_idx == 3'd4) && guard < 100) begin
            tick;
            guard++;
        end
        chk("reach n4", guard < 100, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst calc_enable", calc_enable, 0);
        chk("midrst done", done, 0);
        chk("midrst calc_spikes", calc_spikes, 0);
        chk("midrst neuron_idx", neuron_idx, 0);
        chk("midrst neuron_current", neuron_current, 0);
        guard = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done || busy) guard++;
        end
        chk("midrst quiet", guard, 0);
        run_step(24'h000001, 0, 0, -1, 0, fv, dn);
        chk("post-rst first", fv, 5);
        chk("post-rst done", dn, 34);

        // start coincident with reset is dropped.
        reset = 1'b1; start = 1'b1; input_spikes = 24'h0000FF;
        tick;
        reset = 1'b0; start = 1'b0;
        chk("rst+start busy0", busy, 0);
        tick;
        chk("rst+start busy1", busy, 0);

        for (int i = 0; i < 16; i++) begin
            logic [M-1:0] s;
            s = ($urandom_range(3, 0) == 0) ? '0 : M'($urandom);
            run_step(s, int'($urandom_range(1, 0)), 1, -1, 0, fv, dn);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
